// File: rtl/fc_mac_accumulator_pkg.sv
// Shared widths, element/product/accumulator types, FSM encoding and the
// saturation helper for the fully-connected MAC datapath.
package fc_pkg;

  localparam int DWIDTH = 16;
  localparam int FRAC   = 8;
  localparam int LANES  = 4;
  localparam int ACC_W  = 40;

  typedef logic signed [DWIDTH-1:0]   elem_t;
  typedef logic signed [2*DWIDTH-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam acc_t SAT_MAX = acc_t'((64'sd1 <<< (DWIDTH - 1)) - 64'sd1);
  localparam acc_t SAT_MIN = -SAT_MAX - acc_t'(1);

  // Clamp an already-rescaled accumulator value into the element range.
  function automatic elem_t sat(input acc_t v);
    if (v > SAT_MAX) begin
      return elem_t'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      return elem_t'(SAT_MIN);
    end
    return elem_t'(v);
  endfunction

endpackage

// File: rtl/fc_mac_accumulator_dot8.sv
// Two-stage beat dot product: eight registered signed products, then a
// registered sign-extended sum, with valid/last/bias carried alongside.
module fc_dot8
  import fc_pkg::*;
(
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     valid,
  input  logic                     last,
  input  elem_t                    bias,
  input  logic [LANES*DWIDTH-1:0]  data_a,
  input  logic [LANES*DWIDTH-1:0]  data_b,
  input  logic [LANES*DWIDTH-1:0]  weight_a,
  input  logic [LANES*DWIDTH-1:0]  weight_b,
  output acc_t                     sum,
  output logic                     sum_valid,
  output logic                     sum_last,
  output elem_t                    sum_bias
);

  localparam int NPROD = 2 * LANES;

  prod_t prod     [NPROD];
  prod_t prod_reg [NPROD];
  logic  valid_s1;
  logic  last_s1;
  elem_t bias_s1;
  acc_t  beat_sum;

  // Port A products occupy slots 0..LANES-1, port B the upper half.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign prod[gi] = prod_t'(elem_t'(data_a[gi*DWIDTH +: DWIDTH])) *
                        prod_t'(elem_t'(weight_a[gi*DWIDTH +: DWIDTH]));
      assign prod[LANES+gi] = prod_t'(elem_t'(data_b[gi*DWIDTH +: DWIDTH])) *
                              prod_t'(elem_t'(weight_b[gi*DWIDTH +: DWIDTH]));
    end
  endgenerate

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NPROD; i++) prod_reg[i] <= '0;
      valid_s1 <= 1'b0;
      last_s1  <= 1'b0;
      bias_s1  <= '0;
    end else begin
      for (int i = 0; i < NPROD; i++) prod_reg[i] <= prod[i];
      valid_s1 <= valid;
      last_s1  <= valid && last;
      bias_s1  <= bias;
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NPROD; i++) beat_sum = beat_sum + acc_t'(prod_reg[i]);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sum       <= '0;
      sum_valid <= 1'b0;
      sum_last  <= 1'b0;
      sum_bias  <= '0;
    end else begin
      sum       <= beat_sum;
      sum_valid <= valid_s1;
      sum_last  <= last_s1;
      sum_bias  <= bias_s1;
    end
  end

endmodule

// File: rtl/fc_mac_accumulator.sv
// FC neuron accumulator: run FSM, beat/neuron counters, row accumulator,
// rescale/saturate/ReLU and a single-entry result register with handshake.
module fc_mac_accumulator
  import fc_pkg::*;
#(
  parameter int RAM_DEEP_DATA = 64,
  parameter int OUT           = 2,
  parameter int RELU          = 0
) (
  input  logic                                clk,
  input  logic                                nreset,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic                                in_last,
  input  logic [LANES*DWIDTH-1:0]             data_a,
  input  logic [LANES*DWIDTH-1:0]             data_b,
  input  logic [LANES*DWIDTH-1:0]             weight_a,
  input  logic [LANES*DWIDTH-1:0]             weight_b,
  input  logic [DWIDTH-1:0]                   bias,
  output logic [DWIDTH-1:0]                   result,
  output logic [(OUT > 1 ? $clog2(OUT) : 1)-1:0] result_index,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic                                done,
  output logic                                busy,
  output logic                                err_len,
  output logic                                err_ovf
);

  localparam int BEATS = RAM_DEEP_DATA / (2 * LANES);
  localparam int BW    = $clog2(BEATS) + 1;
  localparam int IW    = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int PW    = $clog2(OUT + 1);

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [IW-1:0]   next_index;
  logic [PW-1:0]   prod_cnt;
  acc_t            acc;
  acc_t            final_val;
  logic            final_valid;
  logic            beat_valid;
  logic            accept;
  acc_t            sum;
  logic            sum_valid;
  logic            sum_last;
  elem_t           sum_bias;
  acc_t            shifted;
  elem_t           rescaled;

  // Beats arriving outside RUN never enter the pipeline.
  assign beat_valid = in_valid && (state == RUN);
  assign accept     = result_valid && result_ready;

  fc_dot8 u_dot8 (
    .clk       (clk),
    .nreset    (nreset),
    .valid     (beat_valid),
    .last      (in_last),
    .bias      (bias),
    .data_a    (data_a),
    .data_b    (data_b),
    .weight_a  (weight_a),
    .weight_b  (weight_b),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_last  (sum_last),
    .sum_bias  (sum_bias)
  );

  always_comb begin
    shifted  = final_val >>> FRAC;
    rescaled = sat(shifted);
    if (RELU != 0 && rescaled < 0) rescaled = '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      next_index   <= '0;
      prod_cnt     <= '0;
      acc          <= '0;
      final_val    <= '0;
      final_valid  <= 1'b0;
      result       <= '0;
      result_index <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      err_len      <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      done <= 1'b0;

      // A short or long row is flagged but still closes normally.
      if (beat_valid) begin
        if (in_last) begin
          beat_cnt <= '0;
          if (beat_cnt != BW'(BEATS - 1)) err_len <= 1'b1;
        end else if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      final_valid <= sum_valid && sum_last;
      if (sum_valid) begin
        if (sum_last) begin
          final_val <= acc + sum + (acc_t'(sum_bias) <<< FRAC);
          acc       <= '0;
        end else begin
          acc <= acc + sum;
        end
      end

      // A fresh result replaces any pending one; losing it is flagged.
      if (final_valid) begin
        result       <= rescaled;
        result_valid <= 1'b1;
        result_index <= next_index;
        next_index   <= (next_index == IW'(OUT - 1)) ? '0 : next_index + 1'b1;
        if (prod_cnt != PW'(OUT)) prod_cnt <= prod_cnt + 1'b1;
        if (result_valid && !result_ready) err_ovf <= 1'b1;
      end else if (accept) begin
        result_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            err_len    <= 1'b0;
            err_ovf    <= 1'b0;
            acc        <= '0;
            beat_cnt   <= '0;
            prod_cnt   <= '0;
            next_index <= '0;
          end
        end
        RUN: begin
          if (accept && !final_valid && prod_cnt == PW'(OUT)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_accumulator.sv
// Directed bench: two instances (RELU off/on) share one stimulus stream;
// expected values are hand-computed Q8.8 results.
module tb_fc_mac_accumulator;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [63:0] data_a = '0, data_b = '0, weight_a = '0, weight_b = '0;
  logic [15:0] bias = '0;
  logic        result_ready = 1'b1;

  logic [15:0] result, result_r;
  logic [0:0]  result_index, result_index_r;
  logic        result_valid, result_valid_r;
  logic        done, done_r, busy, busy_r;
  logic        err_len, err_len_r, err_ovf, err_ovf_r;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fc_mac_accumulator #(.RAM_DEEP_DATA(64), .OUT(2), .RELU(0)) dut (
    .clk(clk), .nreset(nreset), .start(start), .in_valid(in_valid), .in_last(in_last),
    .data_a(data_a), .data_b(data_b), .weight_a(weight_a), .weight_b(weight_b), .bias(bias),
    .result(result), .result_index(result_index), .result_valid(result_valid),
    .result_ready(result_ready), .done(done), .busy(busy), .err_len(err_len), .err_ovf(err_ovf)
  );

  fc_mac_accumulator #(.RAM_DEEP_DATA(64), .OUT(2), .RELU(1)) dut_r (
    .clk(clk), .nreset(nreset), .start(start), .in_valid(in_valid), .in_last(in_last),
    .data_a(data_a), .data_b(data_b), .weight_a(weight_a), .weight_b(weight_b), .bias(bias),
    .result(result_r), .result_index(result_index_r), .result_valid(result_valid_r),
    .result_ready(result_ready), .done(done_r), .busy(busy_r), .err_len(err_len_r),
    .err_ovf(err_ovf_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives nbeats beats of uniform data/weight; optional bubble every 3rd cycle.
  task automatic drive_row(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b,
                           input int nbeats, input bit gaps, input bit with_last);
    int n = 0;
    int cyc = 0;
    while (n < nbeats) begin
      if (gaps && (cyc % 3 == 2)) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_last  = with_last && (n == nbeats - 1);
        data_a   = {4{d}};
        data_b   = {4{d}};
        weight_a = {4{w}};
        weight_b = {4{w}};
        bias     = b;
        n++;
      end
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits (bounded) for a result, checks it, lets it be accepted, checks done/busy.
  task automatic wait_result(input string tag, input logic [15:0] exp, input logic [15:0] exp_r,
                             input int idx, input bit last_one);
    int n = 0;
    while (!result_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, " valid"}, 32'(result_valid), 32'd1);
    check({tag, " result"}, 32'(result), 32'(exp));
    check({tag, " relu_result"}, 32'(result_r), 32'(exp_r));
    check({tag, " index"}, 32'(result_index), 32'(idx));
    tick();
    check({tag, " done"}, 32'(done), 32'(last_one));
    check({tag, " busy"}, 32'(busy), 32'(!last_one));
    if (last_one) begin
      tick();
      check({tag, " done_clear"}, 32'(done), 32'd0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " result"}, 32'(result), 32'd0);
    check({tag, " valid"}, 32'(result_valid), 32'd0);
    check({tag, " index"}, 32'(result_index), 32'd0);
    check({tag, " flags"}, {28'd0, done, busy, err_len, err_ovf}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    nreset = 1'b1;
    tick();
    check_reset_state("reset");

    // 1: 2.0 x 1.0 over 64 pairs = 128.0 -> positive saturation
    start_run();
    check("t1 busy", 32'(busy), 32'd1);
    drive_row(16'h0200, 16'h0100, 16'h0000, 8, 1'b0, 1'b1);
    wait_result("t1 n0", 16'h7FFF, 16'h7FFF, 0, 1'b0);
    drive_row(16'h0200, 16'h0100, 16'h0000, 8, 1'b0, 1'b1);
    wait_result("t1 n1", 16'h7FFF, 16'h7FFF, 1, 1'b1);

    // 2: 0.5 x 0.25 x 64 + 1.0 = 9.0
    start_run();
    drive_row(16'h0080, 16'h0040, 16'h0100, 8, 1'b0, 1'b1);
    wait_result("t2 n0", 16'h0900, 16'h0900, 0, 1'b0);
    drive_row(16'h0080, 16'h0040, 16'h0100, 8, 1'b0, 1'b1);
    wait_result("t2 n1", 16'h0900, 16'h0900, 1, 1'b1);

    // 3: same with bubbles
    start_run();
    drive_row(16'h0080, 16'h0040, 16'h0100, 8, 1'b1, 1'b1);
    wait_result("t3 n0", 16'h0900, 16'h0900, 0, 1'b0);
    drive_row(16'h0080, 16'h0040, 16'h0100, 8, 1'b1, 1'b1);
    wait_result("t3 n1", 16'h0900, 16'h0900, 1, 1'b1);
    check("t3 err_len", 32'(err_len), 32'd0);

    // 4: -4.0 x 1.0 x 64 = -256.0 -> 0x8000, ReLU instance -> 0
    start_run();
    drive_row(16'hFC00, 16'h0100, 16'h0000, 8, 1'b0, 1'b1);
    wait_result("t4 n0", 16'h8000, 16'h0000, 0, 1'b0);
    drive_row(16'hFC00, 16'h0100, 16'h0000, 8, 1'b0, 1'b1);
    wait_result("t4 n1", 16'h8000, 16'h0000, 1, 1'b1);

    // 5: no acceptance across both neurons; neuron 1 (bias 2.0 -> 10.0) overwrites
    result_ready = 1'b0;
    start_run();
    drive_row(16'h0080, 16'h0040, 16'h0100, 8, 1'b0, 1'b1);
    drive_row(16'h0080, 16'h0040, 16'h0200, 8, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("t5 err_ovf", 32'(err_ovf), 32'd1);
    check("t5 valid", 32'(result_valid), 32'd1);
    check("t5 result", 32'(result), 32'h0A00);
    check("t5 index", 32'(result_index), 32'd1);
    check("t5 busy", 32'(busy), 32'd1);
    result_ready = 1'b1;
    tick();
    check("t5 done", 32'(done), 32'd1);
    check("t5 valid_clear", 32'(result_valid), 32'd0);
    tick();

    // 6: short row (7 beats) -> 8.0 with err_len, then reset mid-row
    start_run();
    check("t6 err_ovf_cleared", 32'(err_ovf), 32'd0);
    drive_row(16'h0080, 16'h0040, 16'h0100, 7, 1'b0, 1'b1);
    wait_result("t6 short", 16'h0800, 16'h0800, 0, 1'b0);
    check("t6 err_len", 32'(err_len), 32'd1);
    drive_row(16'h0080, 16'h0040, 16'h0100, 4, 1'b0, 1'b0);
    nreset = 1'b0;
    #1;
    check_reset_state("t6 midrow_reset");
    tick();
    nreset = 1'b1;
    tick();
    start_run();
    drive_row(16'h0080, 16'h0040, 16'h0100, 8, 1'b0, 1'b1);
    wait_result("t6 rerun n0", 16'h0900, 16'h0900, 0, 1'b0);
    drive_row(16'h0080, 16'h0040, 16'h0100, 8, 1'b0, 1'b1);
    wait_result("t6 rerun n1", 16'h0900, 16'h0900, 1, 1'b1);
    check("t6 err_len_after", 32'(err_len), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
